dbg_buf_arbiter: RTL and testbench

Arbiter and sequencer that shares one debug input buffer (receive side) and one debug output buffer (transmit side) between two on-chip requesters, slot 0 (CPU) and slot 1 (debug monitor). It converts per-requester request/acknowledge handshakes into the level strobes the buffers expect. The buffers act on a strobe's rising edge and re-arm only after the strobe is seen low, so this block owns strobe width, strobe recovery, read-data capture and round-robin fairness.

---
 rtl/dbg_buf_arbiter.sv | 140 ++++++++++++++
 tb/tb_dbg_buf_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_buf_arbiter.sv
// Shares one debug input buffer and one debug output buffer between two requesters
// (slot 0 = CPU, slot 1 = debug monitor), generating width-controlled buffer strobes.
module dbg_buf_arbiter #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 13,
  parameter int HOLD  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         wr_req,
  input  logic [2*OUT_W-1:0] wr_data,
  output logic [1:0]         wr_ack,
  input  logic [1:0]         rd_req,
  output logic [IN_W-1:0]    rd_data,
  output logic [1:0]         rd_ack,
  output logic [OUT_W-1:0]   buf_in,
  output logic               buf_writedone,
  input  logic               buf_towrite,
  output logic               buf_read,
  input  logic [IN_W-1:0]    buf_out,
  input  logic               buf_toread
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] STROBE  = 2'd1;
  localparam logic [1:0] RECOVER = 2'd2;
  localparam logic [1:0] ACK     = 2'd3;

  localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

  logic [1:0]       state_q, state_d;
  logic             prio_q, prio_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             slot_q, slot_d;
  logic             op_wr_q, op_wr_d;
  logic [OUT_W-1:0] buf_in_q, buf_in_d;
  logic [IN_W-1:0]  rd_data_q, rd_data_d;
  logic [1:0]       wr_ack_q, wr_ack_d;
  logic [1:0]       rd_ack_q, rd_ack_d;
  logic             wd_q, wd_d;
  logic             rd_q, rd_d;

  logic [1:0] elig;
  logic       gnt;

  assign elig[0] = (wr_req[0] && buf_towrite) || (rd_req[0] && buf_toread);
  assign elig[1] = (wr_req[1] && buf_towrite) || (rd_req[1] && buf_toread);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    slot_d    = slot_q;
    op_wr_d   = op_wr_q;
    buf_in_d  = buf_in_q;
    rd_data_d = rd_data_q;
    wr_ack_d  = 2'b00;
    rd_ack_d  = 2'b00;
    wd_d      = wd_q;
    rd_d      = rd_q;
    gnt       = 1'b0;

    case (state_q)
      IDLE: begin
        if (|elig) begin
          // Round-robin search starts at prio; within a slot a write beats a read.
          gnt     = elig[prio_q] ? prio_q : ~prio_q;
          slot_d  = gnt;
          prio_d  = ~gnt;
          op_wr_d = wr_req[gnt] && buf_towrite;
          cnt_d   = HOLD_M1;
          state_d = STROBE;
          if (wr_req[gnt] && buf_towrite) begin
            buf_in_d = gnt ? wr_data[OUT_W +: OUT_W] : wr_data[0 +: OUT_W];
            wd_d     = 1'b1;
          end else begin
            rd_d     = 1'b1;
          end
        end
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          wd_d    = 1'b0;
          rd_d    = 1'b0;
          state_d = RECOVER;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      RECOVER: begin
        if (op_wr_q) begin
          wr_ack_d[slot_q] = 1'b1;
        end else begin
          rd_ack_d[slot_q] = 1'b1;
          rd_data_d        = buf_out;
        end
        state_d = ACK;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      cnt_q     <= 4'd0;
      slot_q    <= 1'b0;
      op_wr_q   <= 1'b0;
      buf_in_q  <= '0;
      rd_data_q <= '0;
      wr_ack_q  <= 2'b00;
      rd_ack_q  <= 2'b00;
      wd_q      <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      op_wr_q   <= op_wr_d;
      buf_in_q  <= buf_in_d;
      rd_data_q <= rd_data_d;
      wr_ack_q  <= wr_ack_d;
      rd_ack_q  <= rd_ack_d;
      wd_q      <= wd_d;
      rd_q      <= rd_d;
    end
  end

  assign wr_ack        = wr_ack_q;
  assign rd_ack        = rd_ack_q;
  assign rd_data       = rd_data_q;
  assign buf_in        = buf_in_q;
  assign buf_writedone = wd_q;
  assign buf_read      = rd_q;

endmodule

// File: tb/tb_dbg_buf_arbiter.sv
// Directed bench for dbg_buf_arbiter: a cycle-by-cycle vector table followed by
// hand-written sequences for fairness, write/read precedence and mid-strobe reset.
module tb_dbg_buf_arbiter;

  localparam int IN_W  = 16;
  localparam int OUT_W = 13;
  localparam int HOLD  = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         wr_req;
  logic [2*OUT_W-1:0] wr_data;
  logic [1:0]         wr_ack;
  logic [1:0]         rd_req;
  logic [IN_W-1:0]    rd_data;
  logic [1:0]         rd_ack;
  logic [OUT_W-1:0]   buf_in;
  logic               buf_writedone;
  logic               buf_towrite;
  logic               buf_read;
  logic [IN_W-1:0]    buf_out;
  logic               buf_toread;

  int checks = 0;
  int errors = 0;

  dbg_buf_arbiter #(.IN_W(IN_W), .OUT_W(OUT_W), .HOLD(HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_req       (wr_req),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_ack       (rd_ack),
    .buf_in       (buf_in),
    .buf_writedone(buf_writedone),
    .buf_towrite  (buf_towrite),
    .buf_read     (buf_read),
    .buf_out      (buf_out),
    .buf_toread   (buf_toread)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       wr_req;
    logic [OUT_W-1:0] wd0;
    logic [OUT_W-1:0] wd1;
    logic [1:0]       rd_req;
    logic             tw;
    logic             tr;
    logic [IN_W-1:0]  bo;
    logic [1:0]       e_wack;
    logic [1:0]       e_rack;
    logic [IN_W-1:0]  e_rdata;
    logic [OUT_W-1:0] e_bin;
    logic             e_wd;
    logic             e_rd;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for the first nonzero ack, returning it and the number of edges taken.
  task automatic wait_ack(input int budget, output logic [1:0] wa, output logic [1:0] ra,
                          output int n);
    wa = 2'b00;
    ra = 2'b00;
    n  = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if ((wr_ack | rd_ack) != 2'b00) begin
        wa = wr_ack;
        ra = rd_ack;
        n  = i;
        return;
      end
    end
    check("ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [1:0] wa, ra;
    int         n;
    int         nacks;
    int         low_run;
    bit         seen_pulse;
    logic [1:0] ack_slot[4];
    int         ack_cyc[4];

    // Single write, single read, then a write while the input buffer is empty.
    //                wr    wd0       wd1       rd    tw    tr    bo         wack  rack  rdata      bin       wd    rd
    vq.push_back('{2'b01, 13'h0ABC, 13'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b00, 16'h0000, 13'h0ABC, 1'b1, 1'b0});
    vq.push_back('{2'b01, 13'h0ABC, 13'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b00, 16'h0000, 13'h0ABC, 1'b1, 1'b0});
    vq.push_back('{2'b01, 13'h0ABC, 13'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b00, 16'h0000, 13'h0ABC, 1'b0, 1'b0});
    vq.push_back('{2'b01, 13'h0ABC, 13'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 2'b01, 2'b00, 16'h0000, 13'h0ABC, 1'b0, 1'b0});
    vq.push_back('{2'b00, 13'h0ABC, 13'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b00, 16'h0000, 13'h0ABC, 1'b0, 1'b0});
    vq.push_back('{2'b00, 13'h0000, 13'h0000, 2'b10, 1'b1, 1'b1, 16'h1234, 2'b00, 2'b00, 16'h0000, 13'h0ABC, 1'b0, 1'b1});
    vq.push_back('{2'b00, 13'h0000, 13'h0000, 2'b10, 1'b1, 1'b1, 16'h1234, 2'b00, 2'b00, 16'h0000, 13'h0ABC, 1'b0, 1'b1});
    vq.push_back('{2'b00, 13'h0000, 13'h0000, 2'b10, 1'b1, 1'b1, 16'h1234, 2'b00, 2'b00, 16'h0000, 13'h0ABC, 1'b0, 1'b0});
    vq.push_back('{2'b00, 13'h0000, 13'h0000, 2'b10, 1'b1, 1'b1, 16'h1234, 2'b00, 2'b10, 16'h1234, 13'h0ABC, 1'b0, 1'b0});
    vq.push_back('{2'b00, 13'h0000, 13'h0000, 2'b00, 1'b1, 1'b1, 16'hFFFF, 2'b00, 2'b00, 16'h1234, 13'h0ABC, 1'b0, 1'b0});
    vq.push_back('{2'b10, 13'h0000, 13'h1555, 2'b11, 1'b1, 1'b0, 16'hFFFF, 2'b00, 2'b00, 16'h1234, 13'h1555, 1'b1, 1'b0});
    vq.push_back('{2'b10, 13'h0000, 13'h1555, 2'b11, 1'b1, 1'b0, 16'hFFFF, 2'b00, 2'b00, 16'h1234, 13'h1555, 1'b1, 1'b0});
    vq.push_back('{2'b10, 13'h0000, 13'h1555, 2'b11, 1'b1, 1'b0, 16'hFFFF, 2'b00, 2'b00, 16'h1234, 13'h1555, 1'b0, 1'b0});
    vq.push_back('{2'b10, 13'h0000, 13'h1555, 2'b11, 1'b1, 1'b0, 16'hFFFF, 2'b10, 2'b00, 16'h1234, 13'h1555, 1'b0, 1'b0});
    vq.push_back('{2'b00, 13'h0000, 13'h1555, 2'b11, 1'b1, 1'b0, 16'hFFFF, 2'b00, 2'b00, 16'h1234, 13'h1555, 1'b0, 1'b0});
    vq.push_back('{2'b00, 13'h0000, 13'h1555, 2'b11, 1'b1, 1'b0, 16'hFFFF, 2'b00, 2'b00, 16'h1234, 13'h1555, 1'b0, 1'b0});

    rst_n       = 1'b0;
    wr_req      = 2'b00;
    wr_data     = '0;
    rd_req      = 2'b00;
    buf_towrite = 1'b0;
    buf_toread  = 1'b0;
    buf_out     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_wr_ack", wr_ack, 2'b00);
    check("reset_rd_ack", rd_ack, 2'b00);
    check("reset_rd_data", rd_data, 16'h0000);
    check("reset_buf_in", buf_in, 13'h0000);
    check("reset_writedone", buf_writedone, 1'b0);
    check("reset_read", buf_read, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[k]) begin
      @(negedge clk);
      wr_req      = vq[k].wr_req;
      wr_data     = {vq[k].wd1, vq[k].wd0};
      rd_req      = vq[k].rd_req;
      buf_towrite = vq[k].tw;
      buf_toread  = vq[k].tr;
      buf_out     = vq[k].bo;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_wr_ack", k), wr_ack, vq[k].e_wack);
      check($sformatf("v%0d_rd_ack", k), rd_ack, vq[k].e_rack);
      check($sformatf("v%0d_rd_data", k), rd_data, vq[k].e_rdata);
      check($sformatf("v%0d_buf_in", k), buf_in, vq[k].e_bin);
      check($sformatf("v%0d_writedone", k), buf_writedone, vq[k].e_wd);
      check($sformatf("v%0d_read", k), buf_read, vq[k].e_rd);
      check($sformatf("v%0d_one_strobe", k), buf_writedone & buf_read, 1'b0);
    end

    // Both slots reading continuously: grants alternate starting at slot 0, every HOLD+3 cycles.
    @(negedge clk);
    wr_req      = 2'b00;
    rd_req      = 2'b11;
    buf_toread  = 1'b1;
    buf_out     = 16'h00AA;
    nacks       = 0;
    low_run     = 0;
    seen_pulse  = 1'b0;
    for (int c = 0; c < 40 && nacks < 4; c++) begin
      @(posedge clk);
      #1;
      if (buf_read && seen_pulse && low_run > 0)
        check("alt_read_gap", 32'(low_run >= 3), 32'd1);
      if (buf_read) begin
        seen_pulse = 1'b1;
        low_run    = 0;
      end else if (seen_pulse) begin
        low_run++;
      end
      if (rd_ack != 2'b00) begin
        ack_slot[nacks] = rd_ack;
        ack_cyc[nacks]  = c;
        nacks++;
        if (nacks == 4) rd_req = 2'b00;
      end
    end
    check("alt_ack_count", nacks, 4);
    check("alt_rd_data", rd_data, 16'h00AA);
    for (int i = 0; i < nacks; i++) begin
      check($sformatf("alt_slot%0d", i), ack_slot[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) check($sformatf("alt_period%0d", i), ack_cyc[i] - ack_cyc[i-1], HOLD + 3);
    end

    // Slot 0 write+read with slot 1 read pending: write first, then slot 1, then slot 0 read.
    @(negedge clk);
    @(negedge clk);
    wr_req      = 2'b01;
    wr_data     = {13'h0000, 13'h0777};
    rd_req      = 2'b11;
    buf_towrite = 1'b1;
    buf_toread  = 1'b1;
    buf_out     = 16'h0BBB;
    wait_ack(20, wa, ra, n);
    check("prec_first_wr_ack", wa, 2'b01);
    check("prec_first_rd_ack", ra, 2'b00);
    check("prec_buf_in", buf_in, 13'h0777);
    wr_req = 2'b00;
    wait_ack(20, wa, ra, n);
    check("prec_second_rd_ack", ra, 2'b10);
    rd_req = 2'b01;
    wait_ack(20, wa, ra, n);
    check("prec_third_rd_ack", ra, 2'b01);
    check("prec_third_wr_ack", wa, 2'b00);
    rd_req = 2'b00;
    repeat (2) @(negedge clk);

    // Reset during the second strobe cycle of a slot-0 read (which leaves prio at 1).
    rd_req  = 2'b01;
    buf_out = 16'h2222;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("rst_strobe_before", buf_read, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_strobe_async", buf_read, 1'b0);
    check("rst_rd_ack", rd_ack, 2'b00);
    check("rst_rd_data", rd_data, 16'h0000);
    check("rst_buf_in", buf_in, 13'h0000);
    @(negedge clk);
    rd_req = 2'b11;
    rst_n  = 1'b1;
    wait_ack(20, wa, ra, n);
    check("rst_fresh_slot", ra, 2'b01);
    check("rst_fresh_latency", n, HOLD + 2);
    check("rst_fresh_data", rd_data, 16'h2222);
    rd_req = 2'b00;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
